irq_vector_ctrl: RTL and testbench



---
 rtl/irq_vector_ctrl.sv | 173 +++++++++++++++++
 tb/tb_irq_vector_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_vector_ctrl.sv
// Avalon-MM interrupt controller: edge/level latching, masking, fixed priority (lowest index wins) with in-service nesting.
// Latency: readdata 1 cycle after address; irq_out registered one edge after pending/enable/in_service change.
// Backpressure: none -- the slave has no wait states, so every access completes in one cycle.
//
// Ports:
//   clk, reset_n                  system clock, asynchronous active-low reset
//   address/chipselect/write_n    Avalon-MM slave control (write = chipselect && !write_n)
//   writedata/readdata            16-bit data; readdata is registered every clock from address
//   irq_in[NUM_IRQ-1:0]           active-high request lines (optionally synchronized)
//   irq_out                       registered interrupt request to the CPU
module irq_vector_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int SYNC_EN = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    // Bits at and above NUM_IRQ are held at zero in every register.
    localparam logic [15:0] LINE_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_VECTOR  = 3'd3;
    localparam logic [2:0] ADDR_EOI     = 3'd4;
    localparam logic [2:0] ADDR_RAW     = 3'd5;

    logic [15:0] irq_wide;
    logic [15:0] s;
    logic [15:0] s_d;
    logic [15:0] pending;
    logic [15:0] enable_q;
    logic [15:0] edge_q;
    logic [15:0] in_service;

    logic [15:0] below_ceiling;
    logic [15:0] cand;
    logic        vec_vld;
    logic [3:0]  vec_idx;

    logic        wr_en;
    logic        wr_pend;
    logic        wr_enable;
    logic        wr_edge;
    logic        wr_claim;
    logic        wr_eoi;
    logic [15:0] claim_onehot;
    logic [15:0] eoi_onehot;
    logic [15:0] w1c;
    logic [15:0] rise;
    logic [15:0] pending_nxt;
    logic [15:0] in_service_nxt;
    logic [15:0] rd_nxt;

    always_comb begin
        irq_wide                = '0;
        irq_wide[NUM_IRQ-1:0]   = irq_in;
    end

    // Input synchronizer: two flops per line for asynchronous sources, bypassed for same-clock sources.
    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [15:0] sync_a;
            logic [15:0] sync_b;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_a <= '0;
                    sync_b <= '0;
                end else begin
                    sync_a <= irq_wide;
                    sync_b <= sync_a;
                end
            end
            assign s = sync_b;
        end else begin : g_nosync
            assign s = irq_wide;
        end
    endgenerate

    // Register write decode.
    assign wr_en     = chipselect && !write_n;
    assign wr_pend   = wr_en && (address == ADDR_PENDING);
    assign wr_enable = wr_en && (address == ADDR_ENABLE);
    assign wr_edge   = wr_en && (address == ADDR_EDGE);
    assign wr_claim  = wr_en && (address == ADDR_VECTOR);
    assign wr_eoi    = wr_en && (address == ADDR_EOI);

    // Lines strictly below the lowest in-service index may preempt; the in-service line itself
    // and everything of lower priority are blocked until EOI.
    always_comb begin
        logic blocked;
        blocked       = 1'b0;
        below_ceiling = '0;
        for (int i = 0; i < 16; i++) begin
            if (in_service[i]) begin
                blocked = 1'b1;
            end
            if (!blocked) begin
                below_ceiling[i] = 1'b1;
            end
        end
    end

    assign cand    = pending & enable_q & below_ceiling & LINE_MASK;
    assign vec_vld = |cand;

    // Descending scan leaves the lowest set index in vec_idx.
    always_comb begin
        vec_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (cand[i]) begin
                vec_idx = 4'(i);
            end
        end
    end

    assign claim_onehot = (wr_claim && vec_vld) ? (16'd1 << vec_idx) : 16'd0;
    assign eoi_onehot   = wr_eoi ? ((16'd1 << writedata[3:0]) & LINE_MASK) : 16'd0;
    assign w1c          = wr_pend ? writedata : 16'd0;
    assign rise         = s & ~s_d;

    // Edge lines: a new rising edge beats a same-cycle W1C or claim. Level lines track s.
    assign pending_nxt    = ((edge_q & (rise | (pending & ~(w1c | claim_onehot))))
                            | (~edge_q & s)) & LINE_MASK;
    assign in_service_nxt = (in_service | claim_onehot) & ~eoi_onehot & LINE_MASK;

    // Read mux uses pre-write register values, so a same-cycle write is not visible yet.
    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_PENDING: rd_nxt = pending;
            ADDR_ENABLE:  rd_nxt = enable_q;
            ADDR_EDGE:    rd_nxt = edge_q;
            ADDR_VECTOR:  rd_nxt = {vec_vld, 11'b0, vec_idx};
            ADDR_EOI:     rd_nxt = in_service;
            ADDR_RAW:     rd_nxt = s & LINE_MASK;
            default:      rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d        <= '0;
            pending    <= '0;
            enable_q   <= '0;
            edge_q     <= '0;
            in_service <= '0;
            readdata   <= '0;
            irq_out    <= 1'b0;
        end else begin
            s_d        <= s;
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            readdata   <= rd_nxt;
            irq_out    <= vec_vld;
            if (wr_enable) begin
                enable_q <= writedata & LINE_MASK;
            end
            if (wr_edge) begin
                edge_q <= writedata & LINE_MASK;
            end
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Self-checking bench for irq_vector_ctrl (NUM_IRQ=8, SYNC_EN=1): directed scenarios plus random bus/IRQ traffic.
// A behavioural model predicts readdata and irq_out every cycle; directed checks add fixed expected values.
// Stimulus changes on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_irq_vector_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [15:0]   writedata = '0;
    logic [15:0]   readdata;
    logic [N-1:0]  irq_in = '0;
    logic          irq_out;

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    irq_vector_ctrl #(
        .NUM_IRQ (N),
        .SYNC_EN (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: sets of pending/enabled/edge/in-service lines,
    // a 3-deep history of captured inputs standing in for the input latency.
    // ------------------------------------------------------------------
    bit [N-1:0]  m_pend = '0;
    bit [N-1:0]  m_en   = '0;
    bit [N-1:0]  m_edg  = '0;
    bit [N-1:0]  m_ins  = '0;
    bit [N-1:0]  cap_q[$] = '{'0, '0, '0};
    logic [15:0] exp_rd = '0;
    logic        exp_irq = 1'b0;

    function automatic void pick(input bit [N-1:0] pend, input bit [N-1:0] en,
                                 input bit [N-1:0] ins, output bit v, output int idx);
        int ceil_i;
        ceil_i = N;
        for (int i = N - 1; i >= 0; i--) begin
            if (ins[i]) ceil_i = i;
        end
        v   = 1'b0;
        idx = 0;
        for (int i = ceil_i - 1; i >= 0; i--) begin
            if (pend[i] && en[i]) begin
                v   = 1'b1;
                idx = i;
            end
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        bit [N-1:0] s;
        bit [N-1:0] sd;
        bit         v;
        bit         wr;
        int         vi;
        int         claimed;
        int         k;
        if (!reset_n) begin
            m_pend  = '0;
            m_en    = '0;
            m_edg   = '0;
            m_ins   = '0;
            cap_q   = '{'0, '0, '0};
            exp_rd  = '0;
            exp_irq = 1'b0;
        end else begin
            s  = cap_q[1];
            sd = cap_q[2];
            pick(m_pend, m_en, m_ins, v, vi);
            case (address)
                3'd0:    exp_rd = 16'(m_pend);
                3'd1:    exp_rd = 16'(m_en);
                3'd2:    exp_rd = 16'(m_edg);
                3'd3:    exp_rd = v ? (16'h8000 | 16'(vi)) : 16'h0000;
                3'd4:    exp_rd = 16'(m_ins);
                3'd5:    exp_rd = 16'(s);
                default: exp_rd = 16'h0000;
            endcase
            exp_irq = v;
            wr      = chipselect && !write_n;
            claimed = -1;
            if (wr && address == 3'd3 && v) begin
                m_ins[vi] = 1'b1;
                claimed   = vi;
            end
            if (wr && address == 3'd4) begin
                k = int'(writedata[3:0]);
                if (k < N) m_ins[k] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_edg[i]) begin
                    if (s[i] && !sd[i]) m_pend[i] = 1'b1;
                    else if ((wr && address == 3'd0 && writedata[i]) || claimed == i) m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = s[i];
                end
            end
            if (wr && address == 3'd1) m_en  = writedata[N-1:0];
            if (wr && address == 3'd2) m_edg = writedata[N-1:0];
            cap_q.push_front(irq_in);
            void'(cap_q.pop_back());
        end
    end

    // Cycle-by-cycle comparison against the model.
    always begin
        @(posedge clk);
        #1;
        if (check_en) begin
            check("cyc_irq_out", 16'(irq_out), 16'(exp_irq));
            check("cyc_readdata", readdata, exp_rd);
        end
    end

    // ------------------------------------------------------------------
    // Bus and stimulus helpers
    // ------------------------------------------------------------------
    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] lines);
        @(negedge clk);
        irq_in = irq_in | lines;
        @(negedge clk);
        irq_in = irq_in & ~lines;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] v;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        check_en = 1'b1;

        // Reset while lines are pending and in service.
        wr_reg(3'd2, 16'h0003);
        wr_reg(3'd1, 16'h0003);
        pulse(8'h02);
        idle(4);
        wr_reg(3'd3, 16'h0000);
        pulse(8'h01);
        idle(4);
        rd_reg(3'd3, v);
        check("rst_vec_before", v, 16'h8000);
        check("rst_irq_before", 16'(irq_out), 16'h0001);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_irq_async", 16'(irq_out), 16'h0000);
        check("rst_rd_async", readdata, 16'h0000);
        idle(2);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a), v);
            check("rst_reg_zero", v, 16'h0000);
        end

        // Edge mode: single-cycle pulse, latency, W1C.
        wr_reg(3'd1, 16'h0001);
        wr_reg(3'd2, 16'h0001);
        pulse(8'h01);
        edge_tick();
        edge_tick();
        check("edge_irq_e2", 16'(irq_out), 16'h0000);
        edge_tick();
        check("edge_irq_e3", 16'(irq_out), 16'h0001);
        rd_reg(3'd0, v);
        check("edge_pending", v, 16'h0001);
        wr_reg(3'd0, 16'h0001);
        check("edge_irq_at_w1c", 16'(irq_out), 16'h0001);
        edge_tick();
        check("edge_irq_after_w1c", 16'(irq_out), 16'h0000);
        rd_reg(3'd0, v);
        check("edge_pending_clr", v, 16'h0000);

        // Priority and claim.
        wr_reg(3'd2, 16'h0024);
        wr_reg(3'd1, 16'h0024);
        pulse(8'h24);
        idle(4);
        rd_reg(3'd3, v);
        check("prio_vec", v, 16'h8002);
        wr_reg(3'd3, 16'h1234);
        idle(2);
        rd_reg(3'd4, v);
        check("prio_insvc", v, 16'h0004);
        rd_reg(3'd3, v);
        check("prio_vec_claimed", v, 16'h0000);
        check("prio_irq_claimed", 16'(irq_out), 16'h0000);
        wr_reg(3'd4, 16'h0002);
        edge_tick();
        check("prio_irq_eoi", 16'(irq_out), 16'h0001);
        rd_reg(3'd3, v);
        check("prio_vec_eoi", v, 16'h8005);

        // Nesting: higher-priority line preempts while line 5 is in service.
        wr_reg(3'd3, 16'h0000);
        rd_reg(3'd4, v);
        check("nest_insvc5", v, 16'h0020);
        wr_reg(3'd2, 16'h0026);
        wr_reg(3'd1, 16'h0022);
        pulse(8'h02);
        idle(4);
        check("nest_irq", 16'(irq_out), 16'h0001);
        rd_reg(3'd3, v);
        check("nest_vec", v, 16'h8001);
        wr_reg(3'd3, 16'h0000);
        rd_reg(3'd4, v);
        check("nest_insvc", v, 16'h0022);
        wr_reg(3'd4, 16'h0009);
        wr_reg(3'd4, 16'h0003);
        rd_reg(3'd4, v);
        check("eoi_noop", v, 16'h0022);
        wr_reg(3'd4, 16'h0001);
        wr_reg(3'd4, 16'h0005);
        rd_reg(3'd4, v);
        check("eoi_all", v, 16'h0000);

        // Simultaneous W1C and new rising edge on line 3.
        wr_reg(3'd1, 16'h0008);
        wr_reg(3'd2, 16'h0008);
        pulse(8'h08);
        idle(4);
        check("coll_irq_pre", 16'(irq_out), 16'h0001);
        @(negedge clk);
        irq_in[3] = 1'b1;
        @(negedge clk);
        irq_in[3] = 1'b0;
        @(negedge clk);
        address = 3'd0; writedata = 16'h0008; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        rd_reg(3'd0, v);
        check("coll_pending", v, 16'h0008);
        check("coll_irq", 16'(irq_out), 16'h0001);
        wr_reg(3'd0, 16'h0008);
        rd_reg(3'd0, v);
        check("coll_pending_clr", v, 16'h0000);

        // Level mode.
        wr_reg(3'd2, 16'h0000);
        wr_reg(3'd1, 16'h0010);
        @(negedge clk);
        irq_in[4] = 1'b1;
        idle(4);
        wr_reg(3'd0, 16'h0010);
        rd_reg(3'd0, v);
        check("lvl_w1c_ignored", v, 16'h0010);
        wr_reg(3'd3, 16'h0000);
        edge_tick();
        check("lvl_irq_claimed", 16'(irq_out), 16'h0000);
        wr_reg(3'd4, 16'h0004);
        edge_tick();
        check("lvl_irq_eoi", 16'(irq_out), 16'h0001);
        @(negedge clk);
        irq_in[4] = 1'b0;
        address = 3'd0; chipselect = 1'b1; write_n = 1'b1;
        edge_tick();
        edge_tick();
        edge_tick();
        check("lvl_pend_e2", readdata, 16'h0010);
        edge_tick();
        check("lvl_pend_e3", readdata, 16'h0000);

        // Bits above NUM_IRQ and unused addresses.
        wr_reg(3'd1, 16'hFFFF);
        rd_reg(3'd1, v);
        check("mask_enable", v, 16'h00FF);
        wr_reg(3'd6, 16'hFFFF);
        rd_reg(3'd6, v);
        check("addr6_zero", v, 16'h0000);
        rd_reg(3'd7, v);
        check("addr7_zero", v, 16'h0000);

        // Random traffic; the per-cycle model check does the comparing.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, N - 1));
                irq_in[k] = ~irq_in[k];
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1502) reset_n = 1'b1;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
